// File: rtl/decode_if.sv
// Fetch-to-decode and decode-to-execute handshake bundle for decode_stage.
interface decode_if #(
   parameter int unsigned DWIDTH    = 32,
   parameter int unsigned CNT_WIDTH = 8
);
   logic                 in_valid;
   logic                 in_ready;
   logic [DWIDTH-1:0]    instr;
   logic [DWIDTH-1:0]    pc_in;
   logic                 flush;
   logic                 out_valid;
   logic                 out_ready;
   logic [DWIDTH-1:0]    pc_out;
   logic [3:0]           op;
   logic [1:0]           ssel;
   logic [DWIDTH-1:0]    imm;
   logic [4:0]           rs1_id;
   logic [4:0]           rs2_id;
   logic [4:0]           rdst_id;
   logic [2:0]           jump_type;
   logic [DWIDTH-1:0]    jump_addr;
   logic                 we_dmem;
   logic                 we_regfile;
   logic                 en_rdata;
   logic [CNT_WIDTH-1:0] illegal_cnt;

   // Environment side: drives fetch data and downstream ready.
   modport master (
      output in_valid, instr, pc_in, flush, out_ready,
      input  in_ready, out_valid, pc_out, op, ssel, imm, rs1_id, rs2_id, rdst_id,
             jump_type, jump_addr, we_dmem, we_regfile, en_rdata, illegal_cnt
   );

   // Decode stage side.
   modport slave (
      input  in_valid, instr, pc_in, flush, out_ready,
      output in_ready, out_valid, pc_out, op, ssel, imm, rs1_id, rs2_id, rdst_id,
             jump_type, jump_addr, we_dmem, we_regfile, en_rdata, illegal_cnt
   );
endinterface

// File: rtl/decode_stage.sv
// MIPS-subset decode stage: one-entry output register, load-use interlock,
// flush, and a saturating illegal-instruction counter.
module decode_stage #(
   parameter int unsigned DWIDTH    = 32,
   parameter int unsigned CNT_WIDTH = 8
) (
   input logic    clk,
   input logic    rst,
   decode_if.slave bus
);
   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SAT = 4'b0011;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SLT = 4'b0111;
   localparam logic [3:0] OP_NOR = 4'b1100;
   localparam logic [3:0] OP_UND = 4'b1111;
   localparam logic [2:0] JT_NOP  = 3'b000;
   localparam logic [2:0] JT_BEQ  = 3'b001;
   localparam logic [2:0] JT_JAL  = 3'b010;
   localparam logic [2:0] JT_JR   = 3'b011;
   localparam logic [2:0] JT_J    = 3'b100;
   localparam logic [2:0] JT_BODD = 3'b101;

   typedef enum logic [1:0] {EMPTY, FULL, BUBBLE} state_t;

   state_t               state, state_n;
   logic                 lu_pending, lu_pending_n;
   logic [4:0]           lu_rd, lu_rd_n;
   logic [CNT_WIDTH-1:0] cnt_q;
   logic [DWIDTH-1:0]    pc_q, imm_q, ja_q;
   logic [3:0]           op_q;
   logic [1:0]           ssel_q;
   logic [4:0]           rs1_q, rs2_q, rdst_q;
   logic [2:0]           jt_q;
   logic                 wed_q, wer_q, enr_q;

   logic [5:0]        opcode, funct;
   logic [3:0]        d_op, r_op;
   logic              r_ok;
   logic [1:0]        d_ssel;
   logic [DWIDTH-1:0] d_imm, d_ja;
   logic [4:0]        d_rs1, d_rs2, d_rdst;
   logic [2:0]        d_jt;
   logic              d_wed, d_wer, d_enr, d_illegal, d_rd1, d_rd2;
   logic              out_valid_c, in_ready_c, transfer_c, issue_c, hazard_c;
   logic              issuing_load_c, pend_act_c;
   logic [4:0]        pend_rd_c;
   logic              load_c, cnt_inc_c;
   logic              unused_instr;

   assign unused_instr = ^bus.instr;

   // Combinational decode of the presented instruction, including which sources it reads.
   always_comb begin
      opcode    = bus.instr[31:26];
      funct     = bus.instr[5:0];
      d_op      = OP_UND;
      d_ssel    = 2'b00;
      d_imm     = '0;
      d_ja      = '0;
      d_rs1     = 5'd0;
      d_rs2     = 5'd0;
      d_rdst    = 5'd0;
      d_jt      = JT_NOP;
      d_wed     = 1'b0;
      d_wer     = 1'b0;
      d_enr     = 1'b0;
      d_illegal = 1'b1;
      d_rd1     = 1'b0;
      d_rd2     = 1'b0;
      r_ok      = 1'b1;
      case (funct)
         6'b100100: r_op = OP_AND;
         6'b100101: r_op = OP_OR;
         6'b100000: r_op = OP_ADD;
         6'b100010: r_op = OP_SUB;
         6'b100111: r_op = OP_NOR;
         6'b101010: r_op = OP_SLT;
         default: begin
            r_op = OP_UND;
            r_ok = 1'b0;
         end
      endcase
      case (opcode)
         6'b000000: begin
            if (r_ok) begin
               d_op = r_op; d_ssel = 2'b01; d_rdst = bus.instr[15:11]; d_wer = 1'b1;
               d_rs1 = bus.instr[25:21]; d_rs2 = bus.instr[20:16];
               d_illegal = 1'b0; d_rd1 = 1'b1; d_rd2 = 1'b1;
            end else if (funct == 6'b001000) begin
               d_jt = JT_JR; d_rs1 = bus.instr[25:21]; d_rs2 = bus.instr[20:16];
               d_illegal = 1'b0; d_rd1 = 1'b1;
            end
         end
         6'b001000, 6'b001010, 6'b100000, 6'b100011: begin
            d_op  = (opcode == 6'b001010) ? OP_SLT : (opcode == 6'b100000) ? OP_SAT : OP_ADD;
            d_enr = (opcode == 6'b100011);
            d_imm = {{(DWIDTH-16){bus.instr[15]}}, bus.instr[15:0]};
            d_rs1 = bus.instr[25:21]; d_rs2 = bus.instr[20:16]; d_rdst = bus.instr[20:16];
            d_wer = 1'b1; d_illegal = 1'b0; d_rd1 = 1'b1;
         end
         6'b101011, 6'b000100, 6'b000111: begin
            d_op  = (opcode == 6'b101011) ? OP_ADD : OP_UND;
            d_wed = (opcode == 6'b101011);
            d_jt  = (opcode == 6'b000100) ? JT_BEQ : (opcode == 6'b000111) ? JT_BODD : JT_NOP;
            d_imm = {{(DWIDTH-16){bus.instr[15]}}, bus.instr[15:0]};
            d_rs1 = bus.instr[25:21]; d_rs2 = bus.instr[20:16];
            d_illegal = 1'b0; d_rd1 = 1'b1; d_rd2 = (opcode != 6'b000111);
         end
         6'b000011, 6'b000010: begin
            d_ja = {{(DWIDTH-26){bus.instr[25]}}, bus.instr[25:0]};
            d_illegal = 1'b0;
            if (opcode == 6'b000011) begin
               d_op = OP_ADD; d_ssel = 2'b10; d_rdst = 5'd31; d_wer = 1'b1; d_jt = JT_JAL;
            end else begin
               d_jt = JT_J;
            end
         end
         default: ;
      endcase
   end

   // Handshake and interlock; a load leaving this cycle counts as pending too,
   // so its consumer cannot slip in right behind it.
   always_comb begin
      out_valid_c    = (state == FULL);
      issue_c        = out_valid_c && bus.out_ready;
      issuing_load_c = issue_c && enr_q && (rdst_q != 5'd0);
      pend_act_c     = issuing_load_c || (!issue_c && lu_pending);
      pend_rd_c      = issuing_load_c ? rdst_q : lu_rd;
      hazard_c       = bus.in_valid && pend_act_c &&
                       ((d_rd1 && (d_rs1 == pend_rd_c)) || (d_rd2 && (d_rs2 == pend_rd_c)));
      in_ready_c     = !rst && !bus.flush && (state != BUBBLE) && !hazard_c &&
                       (!out_valid_c || bus.out_ready);
      transfer_c     = bus.in_valid && in_ready_c;
   end

   // Next-state logic.
   always_comb begin
      state_n      = state;
      lu_pending_n = lu_pending;
      lu_rd_n      = lu_rd;
      load_c       = 1'b0;
      cnt_inc_c    = 1'b0;
      if (bus.flush) begin
         state_n      = EMPTY;
         lu_pending_n = 1'b0;
      end else if (state == BUBBLE) begin
         state_n      = EMPTY;
         lu_pending_n = 1'b0;
      end else begin
         if (issue_c) begin
            lu_pending_n = enr_q && (rdst_q != 5'd0);
            lu_rd_n      = rdst_q;
         end
         if (transfer_c) begin
            state_n   = FULL;
            load_c    = 1'b1;
            cnt_inc_c = d_illegal;
         end else if (hazard_c && (!out_valid_c || bus.out_ready)) begin
            state_n = BUBBLE;
         end else if (issue_c) begin
            state_n = EMPTY;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= EMPTY; lu_pending <= 1'b0; lu_rd <= 5'd0; cnt_q <= '0;
         pc_q <= '0; imm_q <= '0; ja_q <= '0; op_q <= OP_AND; ssel_q <= 2'b00;
         rs1_q <= 5'd0; rs2_q <= 5'd0; rdst_q <= 5'd0; jt_q <= JT_NOP;
         wed_q <= 1'b0; wer_q <= 1'b0; enr_q <= 1'b0;
      end else begin
         state      <= state_n;
         lu_pending <= lu_pending_n;
         lu_rd      <= lu_rd_n;
         if (cnt_inc_c && (cnt_q != {CNT_WIDTH{1'b1}})) cnt_q <= cnt_q + CNT_WIDTH'(1);
         if (load_c) begin
            pc_q <= bus.pc_in; imm_q <= d_imm; ja_q <= d_ja; op_q <= d_op; ssel_q <= d_ssel;
            rs1_q <= d_rs1; rs2_q <= d_rs2; rdst_q <= d_rdst; jt_q <= d_jt;
            wed_q <= d_wed; wer_q <= d_wer; enr_q <= d_enr;
         end
      end
   end

   assign bus.in_ready    = in_ready_c;
   assign bus.out_valid   = out_valid_c;
   assign bus.pc_out      = pc_q;
   assign bus.op          = op_q;
   assign bus.ssel        = ssel_q;
   assign bus.imm         = imm_q;
   assign bus.rs1_id      = rs1_q;
   assign bus.rs2_id      = rs2_q;
   assign bus.rdst_id     = rdst_q;
   assign bus.jump_type   = jt_q;
   assign bus.jump_addr   = ja_q;
   assign bus.we_dmem     = wed_q;
   assign bus.we_regfile  = wer_q;
   assign bus.en_rdata    = enr_q;
   assign bus.illegal_cnt = cnt_q;
endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: directed scenarios plus random traffic checked
// against a mnemonic-level reference model.
module tb_decode_stage;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   decode_if #(.DWIDTH(32), .CNT_WIDTH(2)) bus ();
   decode_stage #(.DWIDTH(32), .CNT_WIDTH(2)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef enum {M_ADD, M_AND, M_OR, M_SUB, M_NOR, M_SLT, M_JR, M_ADDI, M_SLTI, M_SAT,
                 M_LW, M_SW, M_BEQ, M_BODD, M_JAL, M_J, M_ILL} mn_t;

   typedef struct packed {
      logic [3:0]  op;
      logic [1:0]  ssel;
      logic [31:0] imm;
      logic [4:0]  rs1, rs2, rdst;
      logic [2:0]  jt;
      logic [31:0] ja;
      logic        wed, wer, enr, ill;
      logic [31:0] rmask;
   } bundle_t;

   int n_assert = 0;
   int n_fail   = 0;

   logic        m_full, m_bubble, m_pend, m_zero;
   logic [4:0]  m_pend_rd;
   logic [31:0] m_instr, m_pc;
   int          m_cnt;

   function automatic mn_t classify(input logic [31:0] i);
      case (i[31:26])
         6'b000000:
            case (i[5:0])
               6'b100000: return M_ADD;
               6'b100100: return M_AND;
               6'b100101: return M_OR;
               6'b100010: return M_SUB;
               6'b100111: return M_NOR;
               6'b101010: return M_SLT;
               6'b001000: return M_JR;
               default:   return M_ILL;
            endcase
         6'b001000: return M_ADDI;
         6'b001010: return M_SLTI;
         6'b100000: return M_SAT;
         6'b100011: return M_LW;
         6'b101011: return M_SW;
         6'b000100: return M_BEQ;
         6'b000111: return M_BODD;
         6'b000011: return M_JAL;
         6'b000010: return M_J;
         default:   return M_ILL;
      endcase
   endfunction

   function automatic bundle_t ref_decode(input logic [31:0] i);
      bundle_t b;
      mn_t     m = classify(i);
      logic [31:0] bit_rs = 32'd1 << i[25:21];
      logic [31:0] bit_rt = 32'd1 << i[20:16];
      b = '0;
      b.op  = 4'hF;
      b.ill = (m == M_ILL);
      if (m inside {M_ADD, M_AND, M_OR, M_SUB, M_NOR, M_SLT}) begin
         b.op = (m == M_ADD) ? 4'h2 : (m == M_AND) ? 4'h0 : (m == M_OR) ? 4'h1 :
                (m == M_SUB) ? 4'h6 : (m == M_NOR) ? 4'hC : 4'h7;
         b.ssel = 2'b01; b.rdst = i[15:11]; b.wer = 1'b1; b.rmask = bit_rs | bit_rt;
      end
      if (m inside {M_ADDI, M_SLTI, M_SAT, M_LW}) begin
         b.op = (m == M_SLTI) ? 4'h7 : (m == M_SAT) ? 4'h3 : 4'h2;
         b.rdst = i[20:16]; b.wer = 1'b1; b.enr = (m == M_LW); b.rmask = bit_rs;
      end
      if (m == M_SW)   begin b.op = 4'h2; b.wed = 1'b1; b.rmask = bit_rs | bit_rt; end
      if (m == M_BEQ)  begin b.jt = 3'b001; b.rmask = bit_rs | bit_rt; end
      if (m == M_BODD) begin b.jt = 3'b101; b.rmask = bit_rs; end
      if (m == M_JR)   begin b.jt = 3'b011; b.rmask = bit_rs; end
      if (m inside {M_ADD, M_AND, M_OR, M_SUB, M_NOR, M_SLT, M_JR, M_ADDI, M_SLTI,
                    M_SAT, M_LW, M_SW, M_BEQ, M_BODD}) begin
         b.rs1 = i[25:21]; b.rs2 = i[20:16];
      end
      if (m inside {M_ADDI, M_SLTI, M_SAT, M_LW, M_SW, M_BEQ, M_BODD})
         b.imm = {{16{i[15]}}, i[15:0]};
      if (m inside {M_JAL, M_J}) b.ja = {{6{i[25]}}, i[25:0]};
      if (m == M_JAL) begin b.op = 4'h2; b.ssel = 2'b10; b.rdst = 5'd31; b.wer = 1'b1; b.jt = 3'b010; end
      if (m == M_J)   b.jt = 3'b100;
      return b;
   endfunction

   function automatic logic [31:0] gen_instr();
      logic [5:0]  functs [6];
      logic [5:0]  iops   [9];
      logic [4:0]  rs = 5'($urandom_range(0, 7));
      logic [4:0]  rt = 5'($urandom_range(0, 7));
      logic [4:0]  rd = 5'($urandom_range(0, 7));
      logic [15:0] im = 16'($urandom);
      int          k  = $urandom_range(0, 16);
      functs = '{6'b100000, 6'b100100, 6'b100101, 6'b100010, 6'b100111, 6'b101010};
      iops   = '{6'b001000, 6'b001010, 6'b100000, 6'b100011, 6'b100011, 6'b101011,
                 6'b000100, 6'b000111, 6'b000011};
      if (k < 6)  return {6'b000000, rs, rt, rd, 5'd0, functs[k]};
      if (k == 6) return {6'b000000, rs, 15'd0, 6'b001000};
      if (k < 15) return {iops[k-6], rs, rt, im};
      if (k == 15) return {6'b000010, 26'($urandom)};
      return ($urandom_range(0, 1) == 0) ? {6'b111111, 26'($urandom)} :
                                           {6'b000000, rs, rt, rd, 5'd0, 6'b000001};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_bundle(input bundle_t e, input logic [31:0] pc);
      chk("op", 64'(bus.op), 64'(e.op));
      chk("ssel", 64'(bus.ssel), 64'(e.ssel));
      chk("imm", 64'(bus.imm), 64'(e.imm));
      chk("rs1_id", 64'(bus.rs1_id), 64'(e.rs1));
      chk("rs2_id", 64'(bus.rs2_id), 64'(e.rs2));
      chk("rdst_id", 64'(bus.rdst_id), 64'(e.rdst));
      chk("jump_type", 64'(bus.jump_type), 64'(e.jt));
      chk("jump_addr", 64'(bus.jump_addr), 64'(e.ja));
      chk("enables", 64'({bus.we_dmem, bus.we_regfile, bus.en_rdata}), 64'({e.wed, e.wer, e.enr}));
      chk("pc_out", 64'(bus.pc_out), 64'(pc));
   endtask

   // One clock cycle: drive inputs, check outputs against the model, then advance the model.
   task automatic step(input logic r, input logic f, input logic v, input logic [31:0] ins,
                       input logic [31:0] pc, input logic ordy);
      bundle_t held, inc;
      logic    iss, act, hz, exp_ir;
      logic [4:0] ard;
      @(negedge clk);
      rst = r; bus.flush = f; bus.in_valid = v; bus.instr = ins; bus.pc_in = pc; bus.out_ready = ordy;
      #1;
      held = ref_decode(m_instr);
      inc  = ref_decode(ins);
      iss  = m_full && ordy;
      act  = 1'b0;
      ard  = 5'd0;
      if (iss && held.enr && held.rdst != 5'd0) begin act = 1'b1; ard = held.rdst; end
      else if (!iss && m_pend)                  begin act = 1'b1; ard = m_pend_rd; end
      hz     = v && act && inc.rmask[ard];
      exp_ir = !r && !f && !m_bubble && !hz && (!m_full || ordy);
      chk("in_ready", 64'(bus.in_ready), 64'(exp_ir));
      chk("out_valid", 64'(bus.out_valid), 64'(m_full));
      chk("illegal_cnt", 64'(bus.illegal_cnt), 64'(m_cnt));
      if (m_full) chk_bundle(held, m_pc);
      if (m_zero) chk_bundle('0, 32'd0);
      if (r) begin
         m_full = 1'b0; m_bubble = 1'b0; m_pend = 1'b0; m_cnt = 0; m_zero = 1'b1;
      end else if (f) begin
         m_full = 1'b0; m_bubble = 1'b0; m_pend = 1'b0;
      end else if (m_bubble) begin
         m_bubble = 1'b0; m_pend = 1'b0;
      end else begin
         if (iss) begin m_pend = held.enr && held.rdst != 5'd0; m_pend_rd = held.rdst; end
         if (v && exp_ir) begin
            m_full = 1'b1; m_instr = ins; m_pc = pc; m_zero = 1'b0;
            if (inc.ill && m_cnt < 3) m_cnt++;
         end else if (hz && (!m_full || ordy)) begin
            m_bubble = 1'b1; m_full = 1'b0;
         end else if (iss) begin
            m_full = 1'b0;
         end
      end
   endtask

   initial begin
      int cexp [5];
      cexp = '{1, 2, 3, 3, 3};
      m_full = 1'b0; m_bubble = 1'b0; m_pend = 1'b0; m_pend_rd = 5'd0; m_zero = 1'b0;
      m_instr = 32'd0; m_pc = 32'd0; m_cnt = 0;
      bus.flush = 1'b0; bus.in_valid = 1'b0; bus.instr = 32'd0; bus.pc_in = 32'd0; bus.out_ready = 1'b0;

      // Reset: in_ready low during reset, cleared bundle after it.
      step(1, 0, 1, 32'h00221820, 32'h10, 1);
      step(1, 0, 0, 32'd0, 32'd0, 1);
      step(0, 0, 0, 32'd0, 32'd0, 1);
      chk("rst_op", 64'(bus.op), 64'h0);

      // add $3,$1,$2
      step(0, 0, 1, 32'h00221820, 32'h100, 1);
      step(0, 0, 0, 32'd0, 32'd0, 1);
      chk("add_valid", 64'(bus.out_valid), 64'h1);
      chk("add_fields", 64'({bus.op, bus.ssel, bus.rs1_id, bus.rs2_id, bus.rdst_id, bus.we_regfile}),
          64'({4'b0010, 2'b01, 5'd1, 5'd2, 5'd3, 1'b1}));

      // addi sign extension, then j jump address
      step(0, 0, 1, 32'h2001FFFF, 32'h104, 1);
      step(0, 0, 1, 32'h0A000000, 32'h108, 1);
      chk("addi_imm", 64'(bus.imm), 64'hFFFFFFFF);
      step(0, 0, 0, 32'd0, 32'd0, 1);
      chk("j_fields", 64'({bus.jump_addr, bus.jump_type, bus.we_regfile}),
          64'({32'hFE000000, 3'b100, 1'b0}));

      // lw $5 then dependent add $6,$5,$2
      step(0, 0, 1, 32'h8C250004, 32'h200, 1);
      step(0, 0, 1, 32'h00A23020, 32'h204, 1);
      chk("lu_lw_issue", 64'({bus.out_valid, bus.en_rdata, bus.in_ready}), 64'({1'b1, 1'b1, 1'b0}));
      step(0, 0, 1, 32'h00A23020, 32'h204, 1);
      chk("lu_bubble", 64'({bus.out_valid, bus.in_ready}), 64'({1'b0, 1'b0}));
      step(0, 0, 1, 32'h00A23020, 32'h204, 1);
      chk("lu_accept", 64'(bus.in_ready), 64'h1);
      step(0, 0, 0, 32'd0, 32'd0, 1);
      chk("lu_add_issue", 64'({bus.out_valid, bus.rdst_id}), 64'({1'b1, 5'd6}));

      // Backpressure holds the bundle, then flush empties the stage.
      step(0, 0, 1, 32'h00221820, 32'h300, 0);
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 1, 32'h2001FFFF, 32'h304, 0);
         chk("stall_hold", 64'({bus.in_ready, bus.pc_out}), 64'({1'b0, 32'h300}));
      end
      step(0, 1, 1, 32'h2001FFFF, 32'h304, 0);
      step(0, 0, 0, 32'd0, 32'd0, 0);
      chk("flush_empty", 64'(bus.out_valid), 64'h0);

      // Illegal counter saturates at 3 with CNT_WIDTH 2; reset clears it.
      step(1, 0, 0, 32'd0, 32'd0, 1);
      for (int i = 0; i < 6; i++) begin
         step(0, 0, (i < 5), 32'hFC000000, 32'(32'h400 + 4 * i), 1);
         if (i > 0) begin
            chk("ill_cnt", 64'(bus.illegal_cnt), 64'(cexp[i-1]));
            chk("ill_bundle", 64'({bus.out_valid, bus.op, bus.we_dmem, bus.we_regfile, bus.en_rdata}),
                64'({1'b1, 4'hF, 3'b000}));
         end
      end
      step(0, 0, 1, 32'hFC000000, 32'h500, 1);
      step(1, 0, 1, 32'hFC000000, 32'h504, 1);
      step(0, 0, 0, 32'd0, 32'd0, 1);
      chk("rst_cnt", 64'({bus.illegal_cnt, bus.out_valid}), 64'({2'd0, 1'b0}));

      // Random traffic against the reference model.
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 99) == 0), ($urandom_range(0, 19) == 0),
              ($urandom_range(0, 9) < 7), gen_instr(), $urandom, ($urandom_range(0, 9) < 7));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
